// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_adder_pkg;

    // Controller states: waiting for a start, or consuming operand bits.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Encoding of the mode input.
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_fa_bit.sv
// One-bit full adder used as the arithmetic core of the serial adder.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and majority carry of three bits.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor, operands presented LSB first.
//
// Handshake: a word begins when start is high while IDLE (that edge also
// samples cin and mode and consumes no operand bit). In RUN, an operand bit is
// taken on every edge where bit_valid is high; bit_valid low stalls with all
// state held. Each result bit appears on s with s_valid one cycle after its
// operand bit is taken. done pulses with the last result bit, and cout/ovf are
// valid from then until the next done or reset. start is ignored in RUN but
// is accepted in the done cycle, so words can run back to back.
module serial_adder_n
    import serial_adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SUB_EN = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   start,
    input  logic   cin,
    input  logic   mode,
    input  logic   bit_valid,
    input  logic   a_bit,
    input  logic   b_bit,
    output logic   s,
    output logic   s_valid,
    output logic   cout,
    output logic   ovf,
    output logic   done,
    output logic   busy,
    output state_t dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic            r_carry;
    logic            r_mode_eff;
    logic            r_s;
    logic            r_s_valid;
    logic            r_cout;
    logic            r_ovf;
    logic            r_done;

    logic            w_load;
    logic            w_accept;
    logic            w_last;
    logic            w_mode_in;
    logic            w_b_eff;
    logic            w_sum;
    logic            w_co;

    // Subtraction is a + ~b + ~cin, so the operand and carry are inverted by mode.
    assign w_mode_in = (mode == MODE_SUB) && (SUB_EN != 0);
    assign w_b_eff   = b_bit ^ r_mode_eff;
    assign w_load    = (r_state == ST_IDLE) && start;
    assign w_accept  = (r_state == ST_RUN) && bit_valid;
    assign w_last    = w_accept && (r_cnt == LAST_IDX);

    fa_bit u_fa (
        .a  (a_bit),
        .b  (w_b_eff),
        .ci (r_carry),
        .s  (w_sum),
        .co (w_co)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: leave IDLE on start, return once the last bit is taken.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_next_state = ST_RUN;
            ST_RUN:  if (w_last) w_next_state = ST_IDLE;
            default:             w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: word setup on start, one bit per accepted edge, word flags on the last bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_mode_eff <= 1'b0;
            r_s        <= 1'b0;
            r_s_valid  <= 1'b0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_s_valid <= 1'b0;
            r_done    <= 1'b0;
            if (w_load) begin
                r_carry    <= cin ^ w_mode_in;
                r_mode_eff <= w_mode_in;
                r_cnt      <= '0;
            end else if (w_accept) begin
                r_s       <= w_sum;
                r_s_valid <= 1'b1;
                r_carry   <= w_co;
                if (w_last) begin
                    // Overflow: carry into the sign bit differs from carry out of it.
                    r_cout <= w_co;
                    r_ovf  <= r_carry ^ w_co;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign s         = r_s;
    assign s_valid   = r_s_valid;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign done      = r_done;
    assign busy      = (r_state == ST_RUN);
    assign dbg_state = r_state;

endmodule

// File: doc/serial_adder_n.md
SERIAL_ADDER_N -- requirements
Module: serial_adder_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand word length in bits (>=1).
REQ-002 SHALL have parameter SUB_EN, default 1, meaning subtract mode is available (0: mode input ignored, always add).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin a new word; sampled only in IDLE.
REQ-006 cin  input  1  carry-in (add) / borrow-in (sub), sampled with start.
REQ-007 mode  input  1  0 = add, 1 = subtract (a - b - cin), sampled with start.
REQ-008 bit_valid  input  1  a_bit/b_bit carry a valid operand bit this cycle.
REQ-009 a_bit, b_bit  input  1 each  serial operand bits, LSB first.
REQ-010 s  output  1  registered sum/difference bit.
REQ-011 s_valid  output  1  s holds a new result bit this cycle.
REQ-012 cout  output  1  final carry out of MSB (sub: 1 = no borrow), valid with done.
REQ-013 ovf  output  1  two's-complement overflow of the word, valid with done.
REQ-014 done  output  1  one-cycle pulse marking the last result bit.
REQ-015 busy  output  1  high while in RUN.

Function
REQ-016 FSM SHALL have states IDLE and RUN; IDLE -> RUN on start=1; RUN -> IDLE on the edge accepting bit WIDTH-1.
REQ-017 On start, SHALL load carry register with cin XOR mode_eff, latch mode_eff = mode AND SUB_EN, clear bit counter ($clog2(WIDTH) bits, min 1).
REQ-018 bit_valid SHALL be ignored in IDLE; the start cycle consumes no operand bit.
REQ-019 In RUN with bit_valid=1, per edge: b_eff = b_bit XOR mode_eff; s <= a_bit ^ b_eff ^ carry; carry <= majority(a_bit, b_eff, carry); s_valid <= 1; counter increments.
REQ-020 In RUN with bit_valid=0 (stall), carry, counter and state SHALL hold; s_valid <= 0; s holds.
REQ-021 On the edge accepting bit WIDTH-1, SHALL also set cout <= carry-out of that bit, ovf <= carry-in XOR carry-out of that bit, done <= 1.
REQ-022 done SHALL be high exactly one cycle; cout and ovf SHALL hold their values until the next done or reset.
REQ-023 Latency: each result bit SHALL appear one cycle after its operand bit is accepted; with no stalls done is high WIDTH cycles after the start edge.
REQ-024 start while in RUN SHALL be ignored (no restart, no carry reload).
REQ-025 start SHALL be accepted in the cycle done is high (FSM already IDLE), giving back-to-back words with no gap.
REQ-026 WIDTH=1: ovf SHALL equal initial carry XOR cout.
REQ-027 Counter SHALL never wrap past WIDTH-1 within a word.

Reset
REQ-028 reset=0 SHALL immediately force IDLE and clear s, s_valid, cout, ovf, done, busy, carry, counter, mode_eff to 0, regardless of clock.
REQ-029 Reset mid-word SHALL discard the partial word; first start after release begins a fresh word.

Structure
REQ-030 Package serial_adder_pkg SHALL hold the FSM state typedef and MODE_ADD/MODE_SUB constants.
REQ-031 A combinational sub-module fa_bit (a, b, ci -> s, co) SHALL implement the one-bit full adder; carry/overflow logic lives in serial_adder_n.

Verification (WIDTH=8, bits LSB first)
REQ-032 add 0x5A + 0x33, cin=0 -> serial s = 0x8D, cout=0, ovf=1, done one cycle after 8th bit.
REQ-033 add 0xFF + 0x01, cin=0 -> s = 0x00, cout=1, ovf=0; repeat with cin=1 -> 0x01, cout=1.
REQ-034 sub 0x10 - 0x20, cin=0 -> s = 0xF0, cout=0, ovf=0; sub 0x80 - 0x01 -> 0x7F, cout=1, ovf=1.
REQ-035 Stall: 0x5A + 0x33 with bit_valid low 3 cycles after bit 3 -> same 0x8D, s_valid low in gaps, done 3 cycles later.
REQ-036 Back-to-back: start asserted in done cycle -> second word correct, no idle cycle; start pulsed mid-word -> ignored, first result unchanged.
REQ-037 reset low during bit 4 -> all outputs 0 asynchronously, busy=0; subsequent 0xFF + 0x01 -> 0x00, cout=1.
